// File: rtl/ifetch_pkg.sv
// Shared widths, FSM encoding and record types for the instruction fetch stage.
package ifetch_pkg;

    localparam int WORD   = 32;
    localparam int ADDR   = 32;
    localparam int W_IFST = 2;

    typedef logic [WORD-1:0] word_t;
    typedef logic [ADDR-1:0] addr_t;

    typedef enum logic [W_IFST-1:0] {
        IF_FETCH = 2'd0,
        IF_HOLD  = 2'd1,
        IF_FLUSH = 2'd2
    } if_state_t;

    // One fetched instruction together with the address it came from.
    typedef struct packed {
        logic  v;
        word_t data;
        addr_t addr;
    } fetch_slot_t;

    // Word-granular sequential successor; wraps naturally at the top of the space.
    function automatic addr_t next_pc(input addr_t pc);
        return pc + addr_t'(1);
    endfunction

endpackage

// File: rtl/if_skid.sv
// Single-entry skid buffer: parks the word that lands from memory on the
// cycle decode starts holding, so it can be replayed when the hold lifts.
module if_skid
    import ifetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        clear,
    input  word_t       data_in,
    input  addr_t       addr_in,
    output fetch_slot_t slot
);

    // Clear wins over load so a redirect always empties the buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot <= '0;
        end else if (clear) begin
            slot <= '0;
        end else if (load) begin
            slot.v    <= 1'b1;
            slot.data <= data_in;
            slot.addr <= addr_in;
        end
    end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch stage: drives a synchronous-read instruction memory
// (one cycle latency), registers returning words towards decode, absorbs
// decode stalls through a one-entry skid buffer and redirects on branches.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IF_FETCH | streaming: one read per cycle, returning word goes to decode
// IF_HOLD  | decode holding: no reads, in-flight word parked in the skid
// IF_FLUSH | one cycle after a redirect: read target, drop stale word
module ifetch
    import ifetch_pkg::*;
#(
    parameter addr_t RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic [ADDR-1:0] imem_addr_o,
    output logic            imem_en_o,
    input  logic [WORD-1:0] imem_data_i,
    output logic            v_o,
    output logic [WORD-1:0] inst_o,
    output logic [ADDR-1:0] origaddr_o,
    input  logic            stall_i,
    input  logic            branch_i,
    input  logic [ADDR-1:0] branch_addr_i
);

    if_state_t   state;
    if_state_t   state_next;
    addr_t       pc;
    logic        pend_v;
    addr_t       pend_addr;
    fetch_slot_t dec_slot;
    fetch_slot_t skid;

    logic fetch_en;
    logic take_mem;
    logic take_skid;
    logic squash;
    logic skid_load;
    logic skid_clear;

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IF_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: a redirect takes priority over everything, including a stall.
    always_comb begin
        state_next = state;
        if (branch_i) begin
            state_next = IF_FLUSH;
        end else begin
            case (state)
                IF_FETCH: if (stall_i)  state_next = IF_HOLD;
                IF_HOLD:  if (!stall_i) state_next = IF_FETCH;
                IF_FLUSH: state_next = IF_FETCH;
                default:  state_next = IF_FETCH;
            endcase
        end
    end

    // Per-state control strobes for the memory port, skid and decode registers.
    always_comb begin
        fetch_en   = 1'b0;
        take_mem   = 1'b0;
        take_skid  = 1'b0;
        squash     = 1'b0;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        case (state)
            IF_FETCH: begin
                fetch_en  = !stall_i;
                take_mem  = !stall_i;
                skid_load = stall_i && pend_v;
            end
            IF_HOLD: begin
                fetch_en   = !stall_i;
                take_skid  = !stall_i;
                skid_clear = !stall_i;
            end
            IF_FLUSH: begin
                fetch_en = 1'b1;
                squash   = 1'b1;
            end
            default: begin
                squash = 1'b1;
            end
        endcase
        if (branch_i) begin
            take_mem   = 1'b0;
            take_skid  = 1'b0;
            skid_load  = 1'b0;
            squash     = 1'b1;
            skid_clear = 1'b1;
        end
    end

    // PC and the record of which address the word now on imem_data_i belongs to.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc        <= RESET_PC;
            pend_v    <= 1'b0;
            pend_addr <= '0;
        end else if (branch_i) begin
            pc     <= branch_addr_i;
            pend_v <= 1'b0;
        end else begin
            pend_v <= fetch_en;
            if (fetch_en) begin
                pend_addr <= pc;
                pc        <= next_pc(pc);
            end
        end
    end

    // Decode-facing registers: squash, replay from skid, or take the memory word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dec_slot <= '0;
        end else if (squash) begin
            dec_slot.v <= 1'b0;
        end else if (take_skid) begin
            dec_slot <= skid;
        end else if (take_mem) begin
            if (pend_v) begin
                dec_slot.v    <= 1'b1;
                dec_slot.data <= imem_data_i;
                dec_slot.addr <= pend_addr;
            end else begin
                dec_slot.v <= 1'b0;
            end
        end
    end

    if_skid u_skid (
        .clk     (clk),
        .rst     (rst),
        .load    (skid_load),
        .clear   (skid_clear),
        .data_in (imem_data_i),
        .addr_in (pend_addr),
        .slot    (skid)
    );

    // The read enable is held low for as long as reset is asserted.
    assign imem_en_o   = fetch_en && rst;
    assign imem_addr_o = pc;
    assign v_o         = dec_slot.v;
    assign inst_o      = dec_slot.data;
    assign origaddr_o  = dec_slot.addr;

endmodule

// File: tb/tb_ifetch.sv
// Scoreboard bench for ifetch: a behavioural memory, an expected-stream
// generator (program order from reset/branch targets) and a monitor that
// compares every instruction decode accepts.
`timescale 1ns/1ps
module tb_ifetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_addr;
    logic        imem_en;
    logic [31:0] imem_data = 32'h0;
    logic        v;
    logic [31:0] inst;
    logic [31:0] origaddr;
    logic        stall = 1'b0;
    logic        branch = 1'b0;
    logic [31:0] branch_addr = 32'h0;

    ifetch #(.RESET_PC(RST_PC)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_addr_o   (imem_addr),
        .imem_en_o     (imem_en),
        .imem_data_i   (imem_data),
        .v_o           (v),
        .inst_o        (inst),
        .origaddr_o    (origaddr),
        .stall_i       (stall),
        .branch_i      (branch),
        .branch_addr_i (branch_addr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h0000_1000 + a;
    endfunction

    // Synchronous-read instruction memory.
    always @(posedge clk) begin
        if (imem_en === 1'b1) imem_data <= mem_word(imem_addr);
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] next_addr = RST_PC;
    int          n_pass = 0;
    int          n_total = 0;
    int          n_xfer = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%h, wanted 0x%h", name, act, exp);
    endtask

    // Expected program order: consecutive addresses from the current stream start.
    task automatic topup();
        while (exp_q.size() < 8) begin
            exp_q.push_back('{addr: next_addr, data: mem_word(next_addr)});
            next_addr = next_addr + 32'd1;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        topup();
    endtask

    task automatic drive(input logic s, input logic b, input logic [31:0] ba);
        stall = s;
        branch = b;
        branch_addr = ba;
        if (b) begin
            exp_q.delete();
            next_addr = ba;
        end
        topup();
    endtask

    task automatic wait_addr(input logic [31:0] a, input int limit);
        logic found;
        found = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (v === 1'b1 && origaddr === a) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("reach_addr", 32'(found), 32'd1);
    endtask

    task automatic do_reset(input int hold);
        #3;
        rst = 1'b0;
        stall = 1'b0;
        branch = 1'b0;
        exp_q.delete();
        #1;
        check("rst_now_v", 32'(v), 32'd0);
        check("rst_now_inst", inst, 32'd0);
        check("rst_now_origaddr", origaddr, 32'd0);
        check("rst_now_en", 32'(imem_en), 32'd0);
        repeat (hold) @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        next_addr = RST_PC;
        topup();
    endtask

    task automatic check_startup();
        tick();
        check("start_v_edge1", 32'(v), 32'd0);
        check("start_en_edge1", 32'(imem_en), 32'd1);
        tick();
        check("start_v_edge2", 32'(v), 32'd1);
        for (int k = 0; k < 3; k++) begin
            check("start_origaddr", origaddr, RST_PC + 32'(k));
            check("start_inst", inst, mem_word(RST_PC + 32'(k)));
            if (k < 2) tick();
        end
    endtask

    // Monitor: mid-cycle sample of what the next rising edge will see.
    logic        have_prev = 1'b0;
    logic        p_stall, p_branch, p_v;
    logic [31:0] p_inst, p_orig;

    always @(negedge clk) begin
        #1;
        if (rst !== 1'b1) begin
            have_prev = 1'b0;
            check("rst_v", 32'(v), 32'd0);
            check("rst_inst", inst, 32'd0);
            check("rst_en", 32'(imem_en), 32'd0);
            check("rst_addr", imem_addr, RST_PC);
        end else begin
            if (have_prev) begin
                if (p_branch) begin
                    check("redirect_squash_v", 32'(v), 32'd0);
                end else if (p_stall) begin
                    check("stall_hold_v", 32'(v), 32'(p_v));
                    check("stall_hold_inst", inst, p_inst);
                    check("stall_hold_origaddr", origaddr, p_orig);
                end
            end
            if (stall && !branch && !(have_prev && p_branch))
                check("stall_en_low", 32'(imem_en), 32'd0);
            if (v === 1'b1 && !stall && !branch) begin
                n_xfer++;
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL sb_empty: got origaddr 0x%h, wanted no delivery", origaddr);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sb_origaddr", origaddr, e.addr);
                    check("sb_inst", inst, e.data);
                end
            end
            have_prev = 1'b1;
            p_stall  = stall;
            p_branch = branch;
            p_v      = v;
            p_inst   = inst;
            p_orig   = origaddr;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of run, wanted $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int xfer_start;
        logic [31:0] tgt;

        // Power-up reset and streaming start.
        do_reset(2);
        check_startup();

        // Three-cycle stall while 0x1003 is on the output.
        wait_addr(32'd3, 20);
        drive(1'b1, 1'b0, 32'h0);
        tick(); check("stall_hold_1003_a", inst, 32'h1003);
        tick(); check("stall_hold_1003_b", inst, 32'h1003);
        tick(); check("stall_hold_1003_c", inst, 32'h1003);
        drive(1'b0, 1'b0, 32'h0);
        tick(); check("after_stall_1004", inst, 32'h1004);
        tick(); check("after_stall_1005", inst, 32'h1005);

        // Branch to 0x40 while address 5 is presented.
        wait_addr(32'd5, 20);
        drive(1'b0, 1'b1, 32'h40);
        tick(); drive(1'b0, 1'b0, 32'h0);
        check("branch_v_next", 32'(v), 32'd0);
        tick(); check("branch_flush_v", 32'(v), 32'd0);
        tick();
        check("branch_target_v", 32'(v), 32'd1);
        check("branch_target_addr", origaddr, 32'h40);
        check("branch_target_inst", inst, mem_word(32'h40));

        // Branch and stall together: branch wins.
        drive(1'b1, 1'b0, 32'h0);
        tick(); tick();
        drive(1'b1, 1'b1, 32'h80);
        tick(); drive(1'b0, 1'b0, 32'h0);
        check("stall_branch_v", 32'(v), 32'd0);
        tick(); tick();
        check("stall_branch_target_v", 32'(v), 32'd1);
        check("stall_branch_target_addr", origaddr, 32'h80);

        // Address wrap at the top of the space.
        drive(1'b0, 1'b1, 32'hFFFF_FFFE);
        tick(); drive(1'b0, 1'b0, 32'h0);
        wait_addr(32'hFFFF_FFFF, 10);
        tick();
        check("wrap_v", 32'(v), 32'd1);
        check("wrap_origaddr", origaddr, 32'h0);

        // Reset while holding: everything discarded, restart as from power-up.
        drive(1'b1, 1'b0, 32'h0);
        tick(); tick();
        do_reset(1);
        check_startup();

        // Randomised stalls and redirects.
        xfer_start = n_xfer;
        for (int i = 0; i < 1500; i++) begin
            tick();
            if ($urandom_range(0, 99) < 6) begin
                if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
                else tgt = $urandom;
                drive($urandom_range(0, 99) < 30, 1'b1, tgt);
            end else begin
                drive($urandom_range(0, 99) < 30, 1'b0, 32'h0);
            end
        end
        tick(); drive(1'b0, 1'b0, 32'h0);
        repeat (6) tick();
        check("random_progress", 32'(n_xfer > xfer_start + 500), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
